// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter that shares one cdc_fifo write port among several producers.
// Optional build macro CDC_FIFO_ARB_TAG_EN prepends the granted source index to write_data.
module cdc_fifo_write_arbiter #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int REQUESTERS  = 4,
  parameter  int MAX_BURST   = 4,
  localparam int INDEX_WIDTH = $clog2(REQUESTERS),
`ifdef CDC_FIFO_ARB_TAG_EN
  localparam int WRITE_WIDTH = DATA_WIDTH + INDEX_WIDTH
`else
  localparam int WRITE_WIDTH = DATA_WIDTH
`endif
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            request_valid,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] request_data,
  output logic [REQUESTERS-1:0]            request_ready,
  input  logic                             full,
  output logic [WRITE_WIDTH-1:0]           write_data,
  output logic                             write_increment,
  output logic                             grant_valid,
  output logic [INDEX_WIDTH-1:0]           grant_index
);

  localparam int COUNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(MAX_BURST - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUESTERS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_next;
  logic [COUNT_WIDTH-1:0]  count, count_next;
  logic [INDEX_WIDTH-1:0]  last, last_next;
  logic [INDEX_WIDTH-1:0]  grant, grant_next;
  logic [INDEX_WIDTH-1:0]  pick;
  logic                    sel_valid;
  logic [DATA_WIDTH-1:0]   sel_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      last  <= LAST_INDEX;
      grant <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      last  <= last_next;
      grant <= grant_next;
    end
  end

  // Scan from the farthest offset down so the source nearest after 'last' is what remains.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int off = REQUESTERS; off >= 1; off--) begin
      idx = (int'(last) + off) % REQUESTERS;
      if (request_valid[idx]) begin
        pick = INDEX_WIDTH'(idx);
      end
    end
  end

  assign sel_valid = request_valid[grant];
  assign sel_data  = request_data[grant*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_next      = state;
    count_next      = count;
    last_next       = last;
    grant_next      = grant;
    request_ready   = '0;
    write_increment = 1'b0;
    write_data      = '0;
    grant_valid     = 1'b0;
    grant_index     = '0;

    case (state)
      IDLE: begin
        if (|request_valid) begin
          grant_next = pick;
          count_next = '0;
          state_next = BURST;
        end
      end

      BURST: begin
        grant_valid          = 1'b1;
        grant_index          = grant;
        request_ready[grant] = ~full;
        write_increment      = sel_valid & ~full;
`ifdef CDC_FIFO_ARB_TAG_EN
        write_data           = {grant, sel_data};
`else
        write_data           = sel_data;
`endif
        // While full the grant, count and state are frozen even if the holder drops valid.
        if (!full) begin
          if (sel_valid && count != LAST_COUNT) begin
            count_next = count + 1'b1;
          end else begin
            state_next = IDLE;
            last_next  = grant;
            count_next = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter: spec-level model compared every cycle,
// plus hand-computed literal checks on the logged write stream.
module tb_cdc_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int RQ = 4;
  localparam int MB = 4;
`ifdef CDC_FIFO_ARB_TAG_EN
  localparam int WW = DW + 2;
`else
  localparam int WW = DW;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [RQ-1:0]   request_valid = '0;
  logic [RQ*DW-1:0] request_data = '0;
  logic [RQ-1:0]   request_ready;
  logic            full = 1'b0;
  logic [WW-1:0]   write_data;
  logic            write_increment;
  logic            grant_valid;
  logic [1:0]      grant_index;

  cdc_fifo_write_arbiter #(.DATA_WIDTH(DW), .REQUESTERS(RQ), .MAX_BURST(MB)) dut (
    .clock          (clock),
    .reset          (reset),
    .request_valid  (request_valid),
    .request_data   (request_data),
    .request_ready  (request_ready),
    .full           (full),
    .write_data     (write_data),
    .write_increment(write_increment),
    .grant_valid    (grant_valid),
    .grant_index    (grant_index)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic [WW-1:0] wd;
    int            cyc;
  } entry_t;

  entry_t     log_q[$];
  logic [7:0] src_q[RQ][$];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Model: who holds the port and how many words it has moved, from the arbitration rules.
  logic m_busy;
  int   m_holder;
  int   m_words;
  int   m_last;

  function automatic int next_holder(input int last_src, input logic [RQ-1:0] v);
    for (int k = 1; k <= RQ; k++) begin
      if (v[(last_src + k) % RQ]) return (last_src + k) % RQ;
    end
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy   <= 1'b0;
      m_holder <= 0;
      m_words  <= 0;
      m_last   <= RQ - 1;
    end else if (m_busy) begin
      if (!full) begin
        if (request_valid[m_holder] && (m_words + 1) < MB) begin
          m_words <= m_words + 1;
        end else begin
          m_busy  <= 1'b0;
          m_last  <= m_holder;
          m_words <= 0;
        end
      end
    end else if (request_valid != '0) begin
      m_holder <= next_holder(m_last, request_valid);
      m_words  <= 0;
      m_busy   <= 1'b1;
    end
  end

  always @(negedge clock) begin
    logic [RQ-1:0] exp_ready;
    logic          exp_inc;
    logic [WW-1:0] exp_data;
    logic          exp_gv;
    logic [1:0]    exp_gi;
    exp_ready = '0;
    exp_inc   = 1'b0;
    exp_data  = '0;
    exp_gv    = 1'b0;
    exp_gi    = '0;
    if (reset && m_busy) begin
      exp_gv    = 1'b1;
      exp_gi    = 2'(m_holder);
      exp_ready = full ? '0 : (RQ'(1) << m_holder);
      exp_inc   = request_valid[m_holder] && !full;
`ifdef CDC_FIFO_ARB_TAG_EN
      exp_data  = {2'(m_holder), request_data[m_holder*DW +: DW]};
`else
      exp_data  = request_data[m_holder*DW +: DW];
`endif
    end
    check_output("model_request_ready", 32'(request_ready), 32'(exp_ready));
    check_output("model_write_increment", 32'(write_increment), 32'(exp_inc));
    check_output("model_write_data", 32'(write_data), 32'(exp_data));
    check_output("model_grant_valid", 32'(grant_valid), 32'(exp_gv));
    check_output("model_grant_index", 32'(grant_index), 32'(exp_gi));
  end

  task automatic update_drives();
    for (int i = 0; i < RQ; i++) begin
      if (src_q[i].size() > 0) begin
        request_valid[i]           = 1'b1;
        request_data[i*DW +: DW]   = src_q[i][0];
      end else begin
        request_valid[i]           = 1'b0;
        request_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: log the write seen at mid-cycle, then pop accepted words and set full.
  task automatic apply_stimulus(input logic f);
    logic [RQ-1:0] acc;
    entry_t        e;
    @(negedge clock);
    acc = request_valid & request_ready;
    if (write_increment) begin
      e.src  = int'(grant_index);
      e.data = write_data[DW-1:0];
      e.wd   = write_data;
      e.cyc  = cycle;
      log_q.push_back(e);
    end
    @(posedge clock);
    #2;
    for (int i = 0; i < RQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    full = f;
    update_drives();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (log_q.size() < target && n < budget) begin
      apply_stimulus(1'b0);
      n++;
    end
    check_output(name, 32'(log_q.size()), 32'(target));
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    log_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check_output({name, "_grant_index"}, 32'(grant_index), 32'd0);
    check_output({name, "_request_ready"}, 32'(request_ready), 32'd0);
    check_output({name, "_write_increment"}, 32'(write_increment), 32'd0);
    check_output({name, "_write_data"}, 32'(write_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start_cyc;
    logic [7:0] exp_d;
    int exp_s;

    #1 reset = 1'b0;
    update_drives();
    #2;
    check_idle_outputs("reset_state");
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    // Single source, six words: 4-word burst, regrant, 2 more, release.
    log_q.delete();
    for (int k = 0; k < 6; k++) src_q[0].push_back(8'(8'h10 + k));
    update_drives();
    start_cyc = cycle;
    run_until(6, 40, "single_count");
    if (log_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check_output("single_data", 32'(log_q[k].data), 32'(8'h10 + k));
        check_output("single_src", 32'(log_q[k].src), 32'd0);
      end
      check_output("single_first_latency", 32'(log_q[0].cyc - start_cyc), 32'd1);
      check_output("single_burst_span", 32'(log_q[3].cyc - log_q[0].cyc), 32'd3);
      check_output("single_regrant_gap", 32'(log_q[4].cyc - log_q[3].cyc), 32'd2);
      check_output("single_tail_gap", 32'(log_q[5].cyc - log_q[4].cyc), 32'd1);
    end
    repeat (3) apply_stimulus(1'b0);
    check_output("single_released", 32'(grant_valid), 32'd0);

    // Contention between sources 0 and 2.
    reset_pulse();
    for (int k = 0; k < 8; k++) begin
      src_q[0].push_back(8'(8'h00 + k));
      src_q[2].push_back(8'(8'h20 + k));
    end
    update_drives();
    run_until(16, 80, "contend_count");
    if (log_q.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        exp_s = ((k / 4) % 2 == 1) ? 2 : 0;
        exp_d = 8'((exp_s == 2 ? 8'h20 : 8'h00) + (k / 8) * 4 + (k % 4));
        check_output("contend_src", 32'(log_q[k].src), 32'(exp_s));
        check_output("contend_data", 32'(log_q[k].data), 32'(exp_d));
      end
      check_output("contend_switch_gap", 32'(log_q[4].cyc - log_q[3].cyc), 32'd2);
    end
    repeat (3) apply_stimulus(1'b0);

    // Full stall of 3 cycles after 2 words.
    reset_pulse();
    for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h30 + k));
    update_drives();
    run_until(2, 20, "stall_first_two");
    full = 1'b1;
    #1;
    check_output("stall_ready", 32'(request_ready), 32'd0);
    check_output("stall_increment", 32'(write_increment), 32'd0);
    check_output("stall_grant_index", 32'(grant_index), 32'd1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("stall_no_writes", 32'(log_q.size()), 32'd2);
    run_until(4, 20, "stall_count");
    if (log_q.size() == 4) begin
      check_output("stall_resume_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd4);
      check_output("stall_word3", 32'(log_q[2].data), 32'h32);
      check_output("stall_word4", 32'(log_q[3].data), 32'h33);
      check_output("stall_word4_src", 32'(log_q[3].src), 32'd1);
    end
    repeat (3) apply_stimulus(1'b0);

    // Early release: source 1 sends 2 words, source 3 pending.
    reset_pulse();
    src_q[1].push_back(8'h41);
    src_q[1].push_back(8'h42);
    src_q[3].push_back(8'h61);
    update_drives();
    run_until(3, 30, "early_count");
    if (log_q.size() == 3) begin
      check_output("early_src0", 32'(log_q[0].src), 32'd1);
      check_output("early_src1", 32'(log_q[1].data), 32'h42);
      check_output("early_next_src", 32'(log_q[2].src), 32'd3);
      check_output("early_next_data", 32'(log_q[2].data), 32'h61);
      check_output("early_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd3);
    end
    repeat (3) apply_stimulus(1'b0);

    // Reset mid-burst: source 3 is interrupted after 2 words, source 0 must win afterwards.
    reset_pulse();
    for (int k = 0; k < 4; k++) src_q[3].push_back(8'(8'h70 + k));
    update_drives();
    run_until(1, 20, "midreset_first");
    for (int k = 0; k < 4; k++) src_q[0].push_back(8'(8'h50 + k));
    update_drives();
    run_until(2, 20, "midreset_second");
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset_async");
    @(posedge clock);
    #2 reset = 1'b1;
    log_q.delete();
    run_until(6, 40, "midreset_drain");
    if (log_q.size() == 6) begin
      check_output("midreset_winner", 32'(log_q[0].src), 32'd0);
      check_output("midreset_winner_data", 32'(log_q[0].data), 32'h50);
      check_output("midreset_src3_resume", 32'(log_q[4].data), 32'h72);
    end
    repeat (3) apply_stimulus(1'b0);

    // Source 3 payload, tagged when the tag build is enabled.
    reset_pulse();
    src_q[3].push_back(8'hA5);
    update_drives();
    run_until(1, 20, "tag_count");
    if (log_q.size() == 1) begin
`ifdef CDC_FIFO_ARB_TAG_EN
      check_output("tag_write_data", 32'(log_q[0].wd), 32'h3A5);
`else
      check_output("tag_write_data", 32'(log_q[0].wd), 32'hA5);
`endif
      check_output("tag_src", 32'(log_q[0].src), 32'd3);
    end
    repeat (3) apply_stimulus(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
